dtr_pipe: RTL
=============

// Module: dtr_pipe
// PURPOSE
//  Parametrised WDT-bit x DEPTH-stage pipeline register with valid/ready handshake and per-stage bubble collapse.
//  Successor to the single enable register: adds depth, backpressure, occupancy count and a global freeze.
//  Sits between datapath blocks that need retiming plus flow control without a full FIFO.
// PARAMETERS
//  WDT    7  data width in bits (>=1)
//  DEPTH  3  number of register stages (>=1); also maximum occupancy
// PORTS
//  CLK        in   1                    clock, rising edge
//  RST        in   1                    reset, asynchronous, active-high
//  EN         in   1                    global enable; 0 freezes the whole pipe
//  in_valid   in   1                    upstream word valid
//  in_data    in   WDT                  upstream word
//  in_ready   out  1                    pipe accepts in_data this cycle
//  out_valid  out  1                    stage DEPTH-1 holds a valid word
//  out_data   out  WDT                  word in stage DEPTH-1
//  out_ready  in   1                    downstream accepts out_data
//  count      out  $clog2(DEPTH+1)      number of valid stages, 0..DEPTH
//  FLUSH      in   1                    only present with DTR_PIPE_FLUSH_EN
// BEHAVIOUR
//  - Stage i holds vld[i], dat[i]; stage 0 is fed by in_*, stage DEPTH-1 drives out_*.
//  - Advance (combinational): adv[DEPTH-1] = EN & (~vld[DEPTH-1] | out_ready);
//    adv[i] = EN & (~vld[i] | adv[i+1]); in_ready = adv[0]. Bubbles collapse: an empty stage accepts even when downstream is stalled.
//  - On posedge CLK with adv[i]: vld[i] <= src_vld, where src_vld = in_valid for i=0, else vld[i-1];
//    dat[i] <= src_dat only when src_vld=1, else dat[i] holds. With adv[i]=0, the stage holds.
//  - out_valid = vld[DEPTH-1] & EN; out_data = dat[DEPTH-1] (unmasked).
//  - Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
//  - count: +1 on transfer in only, -1 on transfer out only, unchanged on both/neither; registered and equal to popcount(vld).
//  - Latency, empty pipe, out_ready=1: word transferred in cycle t shows out_valid=1 with that data in cycle t+DEPTH.
//  - Throughput: 1 word/cycle when out_ready=1 steadily, including with the pipe full (count stays DEPTH).
//  - Full pipe with out_ready=0: in_ready=0 and all stages hold; words are never dropped or duplicated.
//  - EN=0: in_ready=0, out_valid=0, no state changes, and count is frozen; resuming EN=1 continues with order intact.
//  - Reset values: all vld=0, all dat=0, count=0, so out_valid=0, out_data=0, and in_ready=0 during RST.
//    RST asserted mid-operation discards in-flight words immediately (async); the first accept is the first edge after release.
//  - Order is strictly FIFO; no reordering across bubbles.
// CONFIGURATION
//  DTR_PIPE_FLUSH_EN defined: adds FLUSH input (sync, active-high, effective only when EN=1).
//    FLUSH=1 at an edge clears all vld and sets count=0; dat registers keep their values.
//    in_ready=0 and out_valid=0 while FLUSH=1, so no transfer in or out occurs that cycle.
//  DTR_PIPE_FLUSH_EN undefined: no FLUSH port, and behaviour is identical to FLUSH tied 0.
// TESTING
//  1 Reset: RST=1 with random inputs -> out_valid=0, out_data=0, count=0, in_ready=0; release -> in_ready=1 (EN=1).
//  2 Latency, DEPTH=3, WDT=7: single word 7'h5A accepted in cycle t, out_ready=1 -> out_valid=1, out_data=7'h5A in cycle t+3 only.
//  3 Backpressure: out_ready=0, stream 1,2,3,4 -> 1,2,3 accepted, count=3, in_ready=0 holding 4;
//    out_ready=1 -> outputs 1,2,3,4 in order at 1/cycle.
//  4 Bubble collapse: accept A, idle 1 cycle, then accept B, with out_ready=0 -> count=2; out_ready=1 -> A then B on consecutive cycles.
//  5 Freeze and reset mid-stream: EN=0 for 5 cycles with a full pipe -> state unchanged, out_valid=0;
//    then RST pulse mid-stream -> count=0 and no stale word appears afterwards.
//  6 Flush (macro on): full pipe, FLUSH=1 for 1 cycle -> count=0, out_valid=0; the next accepted word 7'h11 emerges after DEPTH cycles.

Source files
------------

// File: rtl/dtr_pipe.sv
// dtr_pipe: WDT x DEPTH register pipeline with valid/ready flow control, bubble collapse,
// occupancy count and global freeze (EN). Optional FLUSH input when DTR_PIPE_FLUSH_EN is defined.
module dtr_pipe #(
    parameter int WDT   = 7,
    parameter int DEPTH = 3
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         EN,
    input  logic                         in_valid,
    input  logic [WDT-1:0]               in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [WDT-1:0]               out_data,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef DTR_PIPE_FLUSH_EN
    ,
    input  logic                         FLUSH
`endif
);

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // Handshake: a word crosses an interface at a rising CLK edge where valid and ready
    // are both high; in_ready never depends on in_valid, and out_valid never on out_ready.

    logic [DEPTH-1:0] vld;
    logic [WDT-1:0]   dat     [DEPTH];
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] src_vld;
    logic [WDT-1:0]   src_dat [DEPTH];
    logic             stall_chain;
    logic             flush;
    logic             xfer_in;
    logic             xfer_out;

`ifdef DTR_PIPE_FLUSH_EN
    assign flush = EN & FLUSH;
`else
    assign flush = 1'b0;
`endif

    // A stage advances unless it and every stage after it are full and the sink stalls;
    // this is the unrolled form of adv[i] = EN & (~vld[i] | adv[i+1]).
    always_comb begin
        stall_chain = ~out_ready;
        adv         = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            stall_chain = stall_chain & vld[i];
            adv[i]      = EN & ~stall_chain;
        end
    end

    always_comb begin
        src_vld    = '0;
        src_vld[0] = in_valid;
        src_dat[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            src_vld[i] = vld[i-1];
            src_dat[i] = dat[i-1];
        end
    end

    assign in_ready  = adv[0] & ~RST & ~flush;
    assign out_valid = vld[DEPTH-1] & EN & ~flush;
    assign out_data  = dat[DEPTH-1];
    assign xfer_in   = in_valid & in_ready;
    assign xfer_out  = out_valid & out_ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld   <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat[i] <= '0;
            end
        end else if (flush) begin
            vld   <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (adv[i]) begin
                    vld[i] <= src_vld[i];
                    if (src_vld[i]) begin
                        dat[i] <= src_dat[i];
                    end
                end
            end
            case ({xfer_in, xfer_out})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule
